axil_wr_slave_arbiter: RTL
==========================

# axil_wr_slave_arbiter

Write-channel arbiter for one slave port of the AXI-Lite priority interconnect; one instance per slave, NUMBER_SLAVE instances in total. It picks one of up to NUMBER_MASTER masters whose decoded write address targets this slave, using fixed priority (lowest index wins). It holds the grant for the whole AW/W/B transaction, so the interconnect muxes can route that master's channels. A watchdog releases the grant and flags an error if the slave never completes the transaction.

## Interface
- NUMBER_MASTER, 32: number of requesting masters (≥ 2).
- TIMEOUT_CYCLES, 1024: maximum number of cycles a grant may be held; 0 disables the watchdog.
- IDX_W, $clog2(NUMBER_MASTER): width of grant_idx (derived, not overridden).

- aclk  in  1  clock; all logic rising-edge.
- areset  in  1  synchronous, active-high reset.
- req  in  NUMBER_MASTER  bit i = master i has awvalid high and its address decodes to this slave.
- aw_hs  in  1  AW handshake at the slave port (m_axil awvalid && awready).
- w_hs  in  1  W handshake at the slave port.
- b_hs  in  1  B handshake at the slave port (bvalid && bready).
- grant  out  NUMBER_MASTER  one-hot grant, registered.
- grant_idx  out  IDX_W  binary index of the granted master; 0 when grant_valid is low.
- grant_valid  out  1  a grant is active (OR of grant).
- timeout_err  out  1  one-cycle pulse when the watchdog expires.

## Operation
- States: IDLE, ADDR (waiting for AW and W), RESP (waiting for B).
- IDLE:
  - If req != 0, register grant = the lowest set bit of req, load grant_idx, clear aw_done, w_done and the watchdog counter, and go to ADDR.
  - Otherwise stay in IDLE.
- ADDR:
  - aw_hs sets aw_done and w_hs sets w_done. They may arrive in either order or in the same cycle.
  - Go to RESP in the cycle where (aw_done || aw_hs) && (w_done || w_hs) holds.
  - b_hs in ADDR is ignored.
- RESP: b_hs clears grant, grant_idx and grant_valid, and returns to IDLE.
- The grant is held regardless of req. Deassertion or change of req while granted has no effect, and a higher-priority request never preempts an active grant.
- Duplicate aw_hs or w_hs after the corresponding done flag is set: ignored.
- Watchdog (TIMEOUT_CYCLES > 0):
  - The counter starts at 0 in the first granted cycle and increments every cycle in ADDR or RESP.
  - In the cycle where the counter equals TIMEOUT_CYCLES-1 and no completing b_hs occurs, the next edge clears the grant, goes to IDLE and asserts timeout_err for exactly one cycle.
  - If b_hs coincides with expiry, the transaction is a normal completion and no error is raised.
- Priority is strictly fixed. Starvation of high indices is accepted by design.
- Reset values: state IDLE, grant 0, grant_idx 0, grant_valid 0, timeout_err 0, counter 0, done flags 0. Reset mid-transaction aborts silently, with no timeout_err.

## Timing
- Arbitration latency: req is sampled in IDLE at edge N; grant is visible after edge N, i.e. in cycle N+1.
- Release: b_hs in cycle M; grant is low in cycle M+1; the earliest next grant is in cycle M+2. There is always at least one IDLE cycle between grants.
- Minimum grant length is 2 cycles: aw_hs and w_hs in the first ADDR cycle, then b_hs in the first RESP cycle.
- Maximum grant length with the watchdog enabled is TIMEOUT_CYCLES cycles. timeout_err is high in the same cycle as the first cycle with grant low.
- grant, grant_idx and grant_valid all change on the same edge; there is no combinational path from req to any output.

## Test plan
- Reset then single request:
  - Stimulus: req=32'h0000_0010; aw_hs and w_hs in the first ADDR cycle; b_hs 3 cycles later.
  - Response: grant=32'h10 and grant_idx=4 in the cycle after req; grant=0 in the cycle after b_hs; timeout_err never set.
- Priority and no preemption:
  - Stimulus: req=32'h0000_0030 in IDLE; once granted, raise bit 0.
  - Response: grant_idx=4 is held until b_hs; then master 0 is granted 2 cycles after b_hs.
- Channel ordering:
  - Stimulus: w_hs 2 cycles before aw_hs, then separately aw_hs and w_hs in the same cycle.
  - Response: RESP is entered in the cycle after the second (or shared) handshake; b_hs given early in ADDR is ignored and grant is held.
- Watchdog:
  - Stimulus: TIMEOUT_CYCLES=8, grant master 2, never assert b_hs.
  - Response: grant is high for exactly 8 cycles; timeout_err pulses for 1 cycle as grant falls.
  - Repeat with b_hs on the 8th cycle: no timeout_err.
- Reset mid-operation:
  - Stimulus: assert areset while in RESP with grant_idx=7.
  - Response: all outputs 0 in the next cycle and no timeout_err; after reset release with req still set, master 7 is re-granted 1 cycle later.
- Back-to-back stress:
  - Stimulus: random req over 32 masters for 10k cycles with random handshake delays (TIMEOUT_CYCLES=0).
  - Response: grant is always one-hot or zero; grant_idx matches grant; no dropped or duplicated transactions against a scoreboard.

Source files
------------

// File: rtl/axil_wr_slave_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : axil_wr_slave_arbiter
// Description : Write-channel arbiter for one slave port of the AXI-Lite
//               priority interconnect. Grants the lowest-indexed requesting
//               master and holds the grant for the whole AW/W/B transaction.
//               A watchdog drops the grant and pulses timeout_err if the
//               slave never completes.
// Ports       : aclk        - clock, rising edge
//               areset      - synchronous active-high reset
//               req         - per-master write request for this slave
//               aw_hs/w_hs  - AW / W handshakes at the slave port
//               b_hs        - B handshake at the slave port
//               grant       - registered one-hot grant
//               grant_idx   - binary index of granted master (0 when idle)
//               grant_valid - a grant is active
//               timeout_err - one-cycle pulse on watchdog expiry
// Revision    : 1.0 - initial release
// ============================================================================
module axil_wr_slave_arbiter #(
    parameter int NUMBER_MASTER  = 32,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int IDX_W          = $clog2(NUMBER_MASTER)
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic [NUMBER_MASTER-1:0] req,
    input  logic                     aw_hs,
    input  logic                     w_hs,
    input  logic                     b_hs,
    output logic [NUMBER_MASTER-1:0] grant,
    output logic [IDX_W-1:0]         grant_idx,
    output logic                     grant_valid,
    output logic                     timeout_err
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_ADDR = 2'd1;
    localparam logic [1:0] c_ST_RESP = 2'd2;

    localparam bit c_WD_EN        = (TIMEOUT_CYCLES > 0);
    localparam int c_CNT_W        = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int c_CNT_LAST_I   = c_WD_EN ? (TIMEOUT_CYCLES - 1) : 0;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(c_CNT_LAST_I);

    logic [1:0]               r_state;
    logic [1:0]               w_state_next;
    logic [NUMBER_MASTER-1:0] r_grant;
    logic [IDX_W-1:0]         r_grant_idx;
    logic                     r_aw_done;
    logic                     r_w_done;
    logic [c_CNT_W-1:0]       r_wd_cnt;
    logic                     r_timeout_err;

    logic [NUMBER_MASTER-1:0] w_req_onehot;
    logic [IDX_W-1:0]         w_req_idx;
    logic                     w_busy;
    logic                     w_addr_done;
    logic                     w_expire;

    // Fixed-priority pick: scanning from the top down lets the lowest set
    // bit overwrite any higher one.
    always_comb begin
        w_req_onehot = '0;
        w_req_idx    = '0;
        for (int i = NUMBER_MASTER - 1; i >= 0; i--) begin
            if (req[i]) begin
                w_req_onehot    = '0;
                w_req_onehot[i] = 1'b1;
                w_req_idx       = IDX_W'(i);
            end
        end
    end

    assign w_busy      = (r_state != c_ST_IDLE);
    // A handshake arriving this cycle counts together with a recorded one.
    assign w_addr_done = (r_aw_done || aw_hs) && (r_w_done || w_hs);
    // A B handshake is only a completion in RESP; one that coincides with
    // expiry there wins over the watchdog.
    assign w_expire    = c_WD_EN && w_busy && (r_wd_cnt == c_CNT_LAST) &&
                         !((r_state == c_ST_RESP) && b_hs);

    // State register
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (|req) begin
                    w_state_next = c_ST_ADDR;
                end
            end
            c_ST_ADDR: begin
                if (w_expire) begin
                    w_state_next = c_ST_IDLE;
                end else if (w_addr_done) begin
                    w_state_next = c_ST_RESP;
                end
            end
            c_ST_RESP: begin
                if (b_hs || w_expire) begin
                    w_state_next = c_ST_IDLE;
                end
            end
            default: w_state_next = c_ST_IDLE;
        endcase
    end

    // Grant, done flags and watchdog
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_grant       <= '0;
            r_grant_idx   <= '0;
            r_aw_done     <= 1'b0;
            r_w_done      <= 1'b0;
            r_wd_cnt      <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_timeout_err <= w_expire;
            if (!w_busy) begin
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
                r_wd_cnt  <= '0;
                if (|req) begin
                    r_grant     <= w_req_onehot;
                    r_grant_idx <= w_req_idx;
                end
            end else begin
                r_wd_cnt <= r_wd_cnt + c_CNT_W'(1);
                if (aw_hs) begin
                    r_aw_done <= 1'b1;
                end
                if (w_hs) begin
                    r_w_done <= 1'b1;
                end
                if (w_state_next == c_ST_IDLE) begin
                    r_grant     <= '0;
                    r_grant_idx <= '0;
                end
            end
        end
    end

    // Outputs
    always_comb begin
        grant       = r_grant;
        grant_idx   = r_grant_idx;
        grant_valid = |r_grant;
        timeout_err = r_timeout_err;
    end

endmodule
`default_nettype wire
